// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Brief    : Multi-channel programmable clock divider with glitch-free
//            registered outputs, deferred divisor updates and phase sync.
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 ClkIn,
    input  logic                 ResetN,
    input  logic [CHANNELS-1:0]  Enable,
    input  logic                 Sync,
    input  logic                 DivLoad,
    input  logic [3:0]           DivSel,
    input  logic [CNT_WIDTH-1:0] DivValue,
    output logic [CHANNELS-1:0]  ClkOut,
    output logic [CHANNELS-1:0]  Tick,
    output logic [CHANNELS-1:0]  Pending
);

    localparam logic [CNT_WIDTH-1:0] C_MIN_DIV = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_RST_DIV = CNT_WIDTH'(DEFAULT_DIV);

    // ceil(d/2) without widening: d>>1 plus the odd bit cannot exceed 2^(W-1)
    function automatic logic [CNT_WIDTH-1:0] half_up(input logic [CNT_WIDTH-1:0] d);
        return (d >> 1) + {{(CNT_WIDTH-1){1'b0}}, d[0]};
    endfunction

    logic                 w_sel_ok;
    logic [CNT_WIDTH-1:0] w_div;

    assign w_sel_ok = ({1'b0, DivSel} < 5'(CHANNELS));
    assign w_div    = (DivValue < C_MIN_DIV) ? C_MIN_DIV : DivValue;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic [CNT_WIDTH-1:0] act_q, act_d;
            logic [CNT_WIDTH-1:0] pdiv_q, pdiv_d;
            logic                 pend_q, pend_d;
            logic                 run_q, run_d;
            logic                 clk_q, clk_d;
            logic                 tick_q, tick_d;
            logic                 w_load;
            logic                 w_wrap;
            logic                 w_apply;

            assign w_load  = DivLoad && w_sel_ok && (DivSel == 4'(g));
            assign w_wrap  = run_q && (cnt_q == act_q - C_ONE);
            // A disabled channel has no period in flight, so a held divisor lands at once
            assign w_apply = pend_q && (Sync || w_wrap || !Enable[g]);

            always_comb begin
                cnt_d  = cnt_q;
                act_d  = act_q;
                pdiv_d = pdiv_q;
                pend_d = pend_q;
                run_d  = Enable[g];

                if (w_apply) begin
                    act_d  = pdiv_q;
                    pend_d = 1'b0;
                end

                if (!Enable[g] || Sync || !run_q || w_wrap) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end

                // New writes land after any application so they target the next period
                if (w_load) begin
                    if (Enable[g]) begin
                        pdiv_d = w_div;
                        pend_d = 1'b1;
                    end else begin
                        act_d  = w_div;
                    end
                end

                clk_d  = Enable[g] && (cnt_d < half_up(act_d));
                tick_d = Enable[g] && (cnt_d == act_d - C_ONE);
            end

            always_ff @(posedge ClkIn or negedge ResetN) begin
                if (!ResetN) begin
                    cnt_q  <= '0;
                    act_q  <= C_RST_DIV;
                    pdiv_q <= C_RST_DIV;
                    pend_q <= 1'b0;
                    run_q  <= 1'b0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    act_q  <= act_d;
                    pdiv_q <= pdiv_d;
                    pend_q <= pend_d;
                    run_q  <= run_d;
                    clk_q  <= clk_d;
                    tick_q <= tick_d;
                end
            end

            assign ClkOut[g]  = clk_q;
            assign Tick[g]    = tick_q;
            assign Pending[g] = pend_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clock_divider
// Brief    : Directed and randomized checks of prog_clock_divider against a
//            period-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clock_divider;

    logic        ClkIn = 1'b0;
    logic        ResetN = 1'b0;
    logic [3:0]  Enable = '0;
    logic        Sync = 1'b0;
    logic        DivLoad = 1'b0;
    logic [3:0]  DivSel = '0;
    logic [15:0] DivValue = '0;
    logic [3:0]  ClkOut, Tick, Pending;

    logic        Enable2 = 1'b0;
    logic        DivLoad2 = 1'b0;
    logic [3:0]  DivValue2 = '0;
    logic [0:0]  ClkOut2, Tick2, Pending2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ClkIn = ~ClkIn;

    prog_clock_divider #(.CHANNELS(4), .CNT_WIDTH(16), .DEFAULT_DIV(2)) dut (
        .ClkIn(ClkIn), .ResetN(ResetN), .Enable(Enable), .Sync(Sync),
        .DivLoad(DivLoad), .DivSel(DivSel), .DivValue(DivValue),
        .ClkOut(ClkOut), .Tick(Tick), .Pending(Pending)
    );

    prog_clock_divider #(.CHANNELS(1), .CNT_WIDTH(4), .DEFAULT_DIV(15)) dut_max (
        .ClkIn(ClkIn), .ResetN(ResetN), .Enable(Enable2), .Sync(Sync),
        .DivLoad(DivLoad2), .DivSel(DivSel), .DivValue(DivValue2),
        .ClkOut(ClkOut2), .Tick(Tick2), .Pending(Pending2)
    );

    // Reference model: each channel is a period that started at cycle m_start
    int m_cyc;
    int m_start[4];
    int m_act[4];
    int m_pval[4];
    bit m_pend[4];
    bit m_on[4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_start[i] = 0; m_act[i] = 2; m_pval[i] = 2; m_pend[i] = 0; m_on[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] en, input logic sy, input logic ld,
                              input logic [3:0] sel, input logic [15:0] val);
        m_cyc++;
        for (int i = 0; i < 4; i++) begin
            bit ends;
            ends = m_on[i] && ((m_cyc - m_start[i]) == m_act[i]);
            if (m_pend[i] && (sy || ends || !en[i])) begin
                m_act[i]  = m_pval[i];
                m_pend[i] = 0;
            end
            if (!en[i]) m_on[i] = 0;
            else if (!m_on[i] || sy || ends) begin
                m_on[i]    = 1;
                m_start[i] = m_cyc;
            end
            if (ld && (int'(sel) == i)) begin
                int v;
                v = (int'(val) < 2) ? 2 : int'(val);
                if (en[i]) begin
                    m_pval[i] = v;
                    m_pend[i] = 1;
                end else begin
                    m_act[i] = v;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_clk();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = m_on[i] && ((m_cyc - m_start[i]) < (m_act[i] + 1) / 2);
        return r;
    endfunction

    function automatic logic [3:0] exp_tick();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = m_on[i] && ((m_cyc - m_start[i]) == m_act[i] - 1);
        return r;
    endfunction

    function automatic logic [3:0] exp_pend();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_pend[i];
        return r;
    endfunction

    task automatic tick_clk();
        logic [3:0]  en;
        logic        sy, ld;
        logic [3:0]  sel;
        logic [15:0] val;
        en = Enable; sy = Sync; ld = DivLoad; sel = DivSel; val = DivValue;
        @(posedge ClkIn);
        if (ResetN) model_edge(en, sy, ld, sel, val);
        #1;
    endtask

    task automatic load(input logic [3:0] sel, input logic [15:0] val);
        DivLoad = 1'b1; DivSel = sel; DivValue = val;
        tick_clk();
        DivLoad = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_checks++;
        if (ClkOut !== 4'b0) begin n_errors++; $display("FAIL reset_clkout: got %b want 0000", ClkOut); end
        n_checks++;
        if (Tick !== 4'b0) begin n_errors++; $display("FAIL reset_tick: got %b want 0000", Tick); end
        n_checks++;
        if (Pending !== 4'b0) begin n_errors++; $display("FAIL reset_pending: got %b want 0000", Pending); end
        ResetN = 1'b1;
    endtask

    task automatic test_default_period();
        Enable = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick_clk();
            n_checks++;
            if (ClkOut !== ((k % 2) ? 4'hF : 4'h0)) begin
                n_errors++; $display("FAIL default_clkout k=%0d: got %b want %b", k, ClkOut, (k % 2) ? 4'hF : 4'h0);
            end
            n_checks++;
            if (Tick !== ((k % 2) ? 4'h0 : 4'hF)) begin
                n_errors++; $display("FAIL default_tick k=%0d: got %b want %b", k, Tick, (k % 2) ? 4'h0 : 4'hF);
            end
        end
    endtask

    task automatic test_load_disabled();
        Enable = 4'b1101;
        tick_clk();
        load(4'd1, 16'd5);
        Enable = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            int pos;
            tick_clk();
            pos = (k - 1) % 5;
            n_checks++;
            if (ClkOut[1] !== (pos < 3)) begin
                n_errors++; $display("FAIL div5_clkout k=%0d: got %b want %b", k, ClkOut[1], pos < 3);
            end
            n_checks++;
            if (Tick[1] !== (pos == 4)) begin
                n_errors++; $display("FAIL div5_tick k=%0d: got %b want %b", k, Tick[1], pos == 4);
            end
            n_checks++;
            if (Pending[1] !== 1'b0) begin
                n_errors++; $display("FAIL div5_pending k=%0d: got %b want 0", k, Pending[1]);
            end
        end
    endtask

    task automatic test_pending();
        Enable = 4'b1110;
        tick_clk();
        load(4'd0, 16'd4);
        Enable = 4'hF;
        tick_clk();
        tick_clk();
        load(4'd0, 16'd6);
        n_checks++;
        if ({Pending[0], ClkOut[0]} !== 2'b10) begin
            n_errors++; $display("FAIL pend_c2: got pend/clk %b%b want 10", Pending[0], ClkOut[0]);
        end
        tick_clk();
        n_checks++;
        if ({Pending[0], Tick[0]} !== 2'b11) begin
            n_errors++; $display("FAIL pend_wrap: got pend/tick %b%b want 11", Pending[0], Tick[0]);
        end
        for (int k = 0; k < 12; k++) begin
            int pos;
            tick_clk();
            pos = k % 6;
            n_checks++;
            if ({ClkOut[0], Tick[0], Pending[0]} !== {pos < 3, pos == 5, 1'b0}) begin
                n_errors++;
                $display("FAIL div6 k=%0d: got clk/tick/pend %b%b%b want %b%b0", k,
                         ClkOut[0], Tick[0], Pending[0], pos < 3, pos == 5);
            end
        end
    endtask

    task automatic test_clamp_badsel();
        for (int v = 0; v < 2; v++) begin
            Enable = 4'b1011;
            tick_clk();
            load(4'd2, 16'(v));
            Enable = 4'hF;
            for (int k = 1; k <= 4; k++) begin
                tick_clk();
                n_checks++;
                if ({ClkOut[2], Tick[2]} !== {k % 2 == 1, k % 2 == 0}) begin
                    n_errors++;
                    $display("FAIL clamp_d%0d k=%0d: got clk/tick %b%b want %b%b", v, k,
                             ClkOut[2], Tick[2], k % 2 == 1, k % 2 == 0);
                end
            end
        end
        load(4'd9, 16'd7);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({Pending, ClkOut, Tick} !== {4'b0, exp_clk(), exp_tick()}) begin
                n_errors++;
                $display("FAIL badsel k=%0d: got pend/clk/tick %b/%b/%b want 0000/%b/%b", k,
                         Pending, ClkOut, Tick, exp_clk(), exp_tick());
            end
            tick_clk();
        end
    endtask

    task automatic test_sync();
        Enable = 4'b1100;
        tick_clk();
        load(4'd0, 16'd3);
        load(4'd1, 16'd7);
        Enable = 4'hF;
        repeat ($urandom_range(3, 10)) tick_clk();
        Sync = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            tick_clk();
            Sync = 1'b0;
            if (k == 1) begin
                n_checks++;
                if (ClkOut[1:0] !== 2'b11) begin
                    n_errors++; $display("FAIL sync_rise: got %b want 11", ClkOut[1:0]);
                end
            end
            n_checks++;
            if (Tick[1:0] !== {(k - 1) % 7 == 6, (k - 1) % 3 == 2}) begin
                n_errors++;
                $display("FAIL sync_tick k=%0d: got %b want %b", k, Tick[1:0],
                         {(k - 1) % 7 == 6, (k - 1) % 3 == 2});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) Enable[$urandom_range(0, 3)] ^= 1'b1;
            Sync     = ($urandom_range(0, 31) == 0);
            DivLoad  = ($urandom_range(0, 5) == 0);
            DivSel   = 4'($urandom_range(0, 5));
            DivValue = 16'($urandom_range(0, 9));
            tick_clk();
            n_checks++;
            if (ClkOut !== exp_clk()) begin
                n_errors++; $display("FAIL rand_clkout c=%0d: got %b want %b", c, ClkOut, exp_clk());
            end
            n_checks++;
            if (Tick !== exp_tick()) begin
                n_errors++; $display("FAIL rand_tick c=%0d: got %b want %b", c, Tick, exp_tick());
            end
            n_checks++;
            if (Pending !== exp_pend()) begin
                n_errors++; $display("FAIL rand_pending c=%0d: got %b want %b", c, Pending, exp_pend());
            end
        end
        Sync = 1'b0; DivLoad = 1'b0;
    endtask

    task automatic test_async_reset();
        Enable = 4'hF;
        repeat (3) tick_clk();
        load(4'd0, 16'd5);
        n_checks++;
        if (Pending[0] !== 1'b1) begin
            n_errors++; $display("FAIL areset_pre_pending: got %b want 1", Pending[0]);
        end
        tick_clk();
        #2 ResetN = 1'b0;
        #1;
        n_checks++;
        if ({ClkOut, Tick, Pending} !== 12'b0) begin
            n_errors++;
            $display("FAIL areset_outputs: got clk/tick/pend %b/%b/%b want all 0", ClkOut, Tick, Pending);
        end
        model_reset();
        #2 ResetN = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick_clk();
            n_checks++;
            if ({ClkOut, Tick, Pending} !== {((k % 2) ? 4'hF : 4'h0), ((k % 2) ? 4'h0 : 4'hF), 4'h0}) begin
                n_errors++;
                $display("FAIL areset_after k=%0d: got clk/tick/pend %b/%b/%b", k, ClkOut, Tick, Pending);
            end
        end
    endtask

    task automatic test_max_div();
        Enable2 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            int pos;
            tick_clk();
            pos = (k - 1) % 15;
            n_checks++;
            if ({ClkOut2, Tick2, Pending2} !== {pos < 8, pos == 14, 1'b0}) begin
                n_errors++;
                $display("FAIL maxdiv k=%0d: got clk/tick/pend %b%b%b want %b%b0", k,
                         ClkOut2, Tick2, Pending2, pos < 8, pos == 14);
            end
        end
        Enable2 = 1'b0;
    endtask

    initial begin
        m_cyc = 0;
        test_reset();
        test_default_period();
        test_load_disabled();
        test_pending();
        test_clamp_badsel();
        test_sync();
        test_random();
        test_async_reset();
        test_max_div();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of each channel's divisor and counter.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 2, giving the divisor every channel holds after reset (2..2^CNT_WIDTH-1).
REQ-004 The block SHALL have port ClkIn, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port ResetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port Enable, input, CHANNELS bits: per-channel run enable.
REQ-007 The block SHALL have port Sync, input, 1 bit: one-cycle strobe that phase-aligns all channels.
REQ-008 The block SHALL have port DivLoad, input, 1 bit: divisor write strobe.
REQ-009 The block SHALL have port DivSel, input, 4 bits: channel index for the write.
REQ-010 The block SHALL have port DivValue, input, CNT_WIDTH bits: divisor D to write.
REQ-011 The block SHALL have port ClkOut, output, CHANNELS bits: divided clock per channel.
REQ-012 The block SHALL have port Tick, output, CHANNELS bits: one-ClkIn-cycle pulse per output period, per channel.
REQ-013 The block SHALL have port Pending, output, CHANNELS bits: high while a channel holds a not-yet-applied divisor.

Function
REQ-014 Per channel, state: counter C, active divisor A, pending divisor P, pending flag; ClkOut, Tick and Pending SHALL be flop outputs (glitch-free).
REQ-015 Enabled channel: C SHALL count 0,1,..,A-1 then wrap to 0, one step per ClkIn edge.
REQ-016 ClkOut[i] SHALL be high while C < ceil(A/2), low otherwise: exact 50% duty for even A, high one extra cycle for odd A.
REQ-017 Tick[i] SHALL be high exactly in the cycle where C == A-1 (the wrap cycle).
REQ-018 A DivLoad with DivSel >= CHANNELS SHALL be ignored.
REQ-019 DivValue 0 or 1 SHALL be stored as 2 (clamp); other values stored unchanged.
REQ-020 DivLoad to an enabled channel SHALL write P and set pending; at the next wrap edge A <= P, pending cleared; C wraps to 0 and the new period starts with the new divisor.
REQ-021 DivLoad in the wrap cycle itself SHALL set pending, applied at the following wrap, not the current one.
REQ-022 A second DivLoad before the wrap SHALL overwrite P; only the last value is applied.
REQ-023 DivLoad to a disabled channel SHALL write A directly next edge; pending stays clear.
REQ-024 Enable[i] low: C held at 0, ClkOut[i]=0, Tick[i]=0 from the next edge; on re-enable, C counts from 0 with ClkOut high in the first enabled cycle.
REQ-025 Sync high: every channel C <= 0 on that edge; any pending P applied to A, pending cleared; Sync takes precedence over a simultaneous wrap.
REQ-026 Sync and DivLoad on the same edge: Sync applies to existing P, then the new write becomes pending for the targeted enabled channel.
REQ-027 Counter arithmetic SHALL be modulo A, never overflow CNT_WIDTH; A == 2^CNT_WIDTH-1 SHALL work.

Reset
REQ-028 ResetN low SHALL asynchronously set all C=0, A=DEFAULT_DIV, P=DEFAULT_DIV, pending=0, ClkOut=0, Tick=0, Pending=0.
REQ-029 After ResetN deasserts, enabled channels SHALL start counting at the first ClkIn rising edge; reset mid-period SHALL discard pending writes.

Verification
REQ-030 Reset, Enable=4'b1111, defaults -> all ClkOut toggle every cycle (period 2), Tick high every second cycle.
REQ-031 Disabled ch1, load D=5, enable -> ClkOut[1] high 3 cycles, low 2; Tick[1] every 5th cycle.
REQ-032 Ch0 running D=4, load D=6 at C=1 -> Pending[0] high until wrap; period 4 completes, then period 6.
REQ-033 Load D=0 and D=1 to ch2 -> both behave as D=2; DivSel=9 with CHANNELS=4 -> no channel changes.
REQ-034 Ch0 D=3, ch1 D=7 running, assert Sync -> both C=0 next cycle, both ClkOut rise together, Tick coincide every 21 cycles.
REQ-035 Assert ResetN low mid-period with pending write -> outputs 0 immediately (no clock edge), A returns to DEFAULT_DIV, pending lost.
